// File: rtl/csc_rgb_packer.sv
// BT.601 YUV->RGB convert plus SRAM packer, two pixels into three 16-bit words; optional CSC_CLIP_STATS_EN adds Clip_count_O.
// Latency: a pixel accepted in cycle n is visible in the packer FIFO in cycle n+2; at most one word is written per cycle.
// Backpressure: Wr_stall_I holds the presented word; Pix_ready_O drops once the FIFO and the pipe together hold FIFO_DEPTH pixels.

module csc_rgb_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign pop_dat_o = mem_q[rd_ptr_q];
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
endmodule

module csc_rgb_packer #(
    parameter int          IMG_WIDTH  = 320,
    parameter int          IMG_HEIGHT = 240,
    parameter logic [17:0] RGB_BASE   = 18'd146944,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Start_I,
    input  logic        Pix_valid_I,
    output logic        Pix_ready_O,
    input  logic [7:0]  Y_I,
    input  logic [7:0]  U_I,
    input  logic [7:0]  V_I,
    input  logic        Wr_stall_I,
    output logic        Wr_en_O,
    output logic [17:0] Wr_address_O,
    output logic [15:0] Wr_data_O,
    output logic        Busy_O,
    output logic        Done_O
`ifdef CSC_CLIP_STATS_EN
    ,
    output logic [15:0] Clip_count_O
`endif
);
    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int PCW  = $clog2(NPIX + 1);
    localparam int FCW  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_W0, S_W1, S_W2, S_DONE} state_e;

    function automatic logic [7:0] clip8(input logic signed [31:0] x);
        if (x < 0)   return 8'd0;
        if (x > 255) return 8'hFF;
        return x[7:0];
    endfunction

    logic              pix_take, room, busy, done_p, start_acc, wr_en, pop;
    logic [15:0]       wr_dat;
    logic [FCW-1:0]    fifo_count;
    logic              fifo_empty;
    logic [23:0]       fifo_dat, push_dat;
    logic [7:0]        f_r, f_g, f_b;

    // Stage 1: centre the components and register the five coefficient products.
    logic signed [8:0]  y_s, u_s, v_s;
    logic               s1_vld_q;
    logic signed [31:0] prod_y_q, prod_rv_q, prod_gu_q, prod_gv_q, prod_bu_q;

    assign y_s = $signed({1'b0, Y_I}) - 9'sd16;
    assign u_s = $signed({1'b0, U_I}) - 9'sd128;
    assign v_s = $signed({1'b0, V_I}) - 9'sd128;

    always_ff @(posedge Clock) begin
        if (!Resetn) s1_vld_q <= 1'b0;
        else         s1_vld_q <= pix_take;
    end

    always_ff @(posedge Clock) begin
        if (pix_take) begin
            prod_y_q  <= 32'sd76284  * 32'(y_s);
            prod_rv_q <= 32'sd104595 * 32'(v_s);
            prod_gu_q <= 32'sd25624  * 32'(u_s);
            prod_gv_q <= 32'sd53281  * 32'(v_s);
            prod_bu_q <= 32'sd132251 * 32'(u_s);
        end
    end

    // Stage 2: sum, floor-shift and clip; the result goes straight into the FIFO.
    logic signed [31:0] r_full, g_full, b_full;

    assign r_full   = (prod_y_q + prod_rv_q) >>> 16;
    assign g_full   = (prod_y_q - prod_gu_q - prod_gv_q) >>> 16;
    assign b_full   = (prod_y_q + prod_bu_q) >>> 16;
    assign push_dat = {clip8(r_full), clip8(g_full), clip8(b_full)};

    csc_rgb_fifo #(
        .WIDTH (24),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (Clock),
        .rst_ni     (Resetn),
        .push_i     (s1_vld_q),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .pop_dat_o  (fifo_dat),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    assign f_r = fifo_dat[23:16];
    assign f_g = fifo_dat[15:8];
    assign f_b = fifo_dat[7:0];

    // Pixels still in stage 1 are counted against FIFO space so a push can never overflow.
    assign room        = (32'(fifo_count) + 32'(s1_vld_q)) < 32'(FIFO_DEPTH);
    assign Pix_ready_O = busy & room;
    assign pix_take    = Pix_valid_I & Pix_ready_O;

    state_e         state_q, state_d;
    logic [17:0]    addr_q, addr_d;
    logic [PCW-1:0] pix_cnt_q, pix_cnt_d;
    logic [7:0]     b_hold_q, b_hold_d, g_hold_q, g_hold_d;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q   <= S_IDLE;
            addr_q    <= RGB_BASE;
            pix_cnt_q <= '0;
            b_hold_q  <= '0;
            g_hold_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pix_cnt_q <= pix_cnt_d;
            b_hold_q  <= b_hold_d;
            g_hold_q  <= g_hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pix_cnt_d = pix_cnt_q;
        b_hold_d  = b_hold_q;
        g_hold_d  = g_hold_q;
        wr_en     = 1'b0;
        wr_dat    = '0;
        pop       = 1'b0;
        busy      = 1'b0;
        done_p    = 1'b0;
        start_acc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start_I) begin
                    start_acc = 1'b1;
                    state_d   = S_W0;
                    addr_d    = RGB_BASE;
                    pix_cnt_d = '0;
                end
            end
            S_W0: begin
                busy   = 1'b1;
                wr_en  = ~fifo_empty;
                wr_dat = {f_r, f_g};
                if (!fifo_empty && !Wr_stall_I) begin
                    pop       = 1'b1;
                    b_hold_d  = f_b;
                    pix_cnt_d = pix_cnt_q + PCW'(1);
                    addr_d    = addr_q + 18'd1;
                    state_d   = S_W1;
                end
            end
            S_W1: begin
                busy   = 1'b1;
                wr_en  = ~fifo_empty;
                wr_dat = {b_hold_q, f_r};
                if (!fifo_empty && !Wr_stall_I) begin
                    pop       = 1'b1;
                    g_hold_d  = f_g;
                    b_hold_d  = f_b;
                    pix_cnt_d = pix_cnt_q + PCW'(1);
                    addr_d    = addr_q + 18'd1;
                    state_d   = S_W2;
                end
            end
            S_W2: begin
                busy   = 1'b1;
                wr_en  = 1'b1;
                wr_dat = {g_hold_q, b_hold_q};
                if (!Wr_stall_I) begin
                    if (pix_cnt_q == PCW'(NPIX)) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 18'd1;
                        state_d = S_W0;
                    end
                end
            end
            S_DONE: begin
                done_p  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Address and data read as zero whenever no write is requested.
    assign Wr_en_O      = wr_en;
    assign Wr_address_O = wr_en ? addr_q : '0;
    assign Wr_data_O    = wr_en ? wr_dat : '0;
    assign Busy_O       = busy;
    assign Done_O       = done_p;

`ifdef CSC_CLIP_STATS_EN
    function automatic logic clipped(input logic signed [31:0] x);
        return (x < 0) || (x > 255);
    endfunction

    logic [1:0]  clip_inc;
    logic [16:0] clip_sum;
    logic [15:0] clip_cnt_q, clip_cnt_d;

    assign clip_inc = 2'(clipped(r_full)) + 2'(clipped(g_full)) + 2'(clipped(b_full));
    assign clip_sum = {1'b0, clip_cnt_q} + 17'(clip_inc);

    always_comb begin
        clip_cnt_d = clip_cnt_q;
        if (start_acc)     clip_cnt_d = '0;
        else if (s1_vld_q) clip_cnt_d = clip_sum[16] ? 16'hFFFF : clip_sum[15:0];
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) clip_cnt_q <= '0;
        else         clip_cnt_q <= clip_cnt_d;
    end

    assign Clip_count_O = clip_cnt_q;
`endif
endmodule

// File: tb/tb_csc_rgb_packer.sv
// Directed bench for csc_rgb_packer on a 4x2 frame, checked against a byte-stream model of the RGB packing.
module tb_csc_rgb_packer;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NW   = W * H * 3 / 2;
    localparam int BASE = 146944;

    logic        Clock       = 1'b0;
    logic        Resetn      = 1'b0;
    logic        Start_I     = 1'b0;
    logic        Pix_valid_I = 1'b0;
    logic [7:0]  Y_I = '0, U_I = '0, V_I = '0;
    logic        Wr_stall_I  = 1'b0;
    logic        Pix_ready_O, Wr_en_O, Busy_O, Done_O;
    logic [17:0] Wr_address_O;
    logic [15:0] Wr_data_O;
`ifdef CSC_CLIP_STATS_EN
    logic [15:0] Clip_count_O;
`endif

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [7:0] tab_y [8] = '{8'd235, 8'd16, 8'd255, 8'd0, 8'd128, 8'd100, 8'd180, 8'd60};
    logic [7:0] tab_u [8] = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd110, 8'd140, 8'd120};
    logic [7:0] tab_v [8] = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd140, 8'd120, 8'd130};

    csc_rgb_packer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .RGB_BASE   (18'(BASE)),
        .FIFO_DEPTH (4)
    ) dut (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .Start_I      (Start_I),
        .Pix_valid_I  (Pix_valid_I),
        .Pix_ready_O  (Pix_ready_O),
        .Y_I          (Y_I),
        .U_I          (U_I),
        .V_I          (V_I),
        .Wr_stall_I   (Wr_stall_I),
        .Wr_en_O      (Wr_en_O),
        .Wr_address_O (Wr_address_O),
        .Wr_data_O    (Wr_data_O),
        .Busy_O       (Busy_O),
        .Done_O       (Done_O)
`ifdef CSC_CLIP_STATS_EN
        ,
        .Clip_count_O (Clip_count_O)
`endif
    );

    always #10 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Floor division by 2^16, built from truncating division.
    function automatic int fl16(input int x);
        int q;
        q = x / 65536;
        if (x < 0 && (x % 65536) != 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [7:0] sat8(input int x);
        if (x < 0)   return 8'd0;
        if (x > 255) return 8'd255;
        return 8'(x);
    endfunction

    function automatic int nclip(input int x);
        return (x < 0 || x > 255) ? 1 : 0;
    endfunction

    // Model: each pixel appends R,G,B to a byte stream; every two bytes form the next word.
    logic [7:0]  byte_q [$];
    logic [33:0] exp_q  [$];
    int          gen_idx = 0, taken = 0, m_clip = 0, log_n = 0;
    bit          m_busy = 0, m_done = 0, hold_chk = 0;
    logic [17:0] hold_a;
    logic [15:0] hold_d;
    logic [17:0] log_a [NW];
    logic [15:0] log_d [NW];
    int          log_c [NW];

    always @(negedge Clock) begin
        bit   cur_busy, cur_done, nxt_done;
        int   y, u, v, r, g, b;
        logic [7:0] b0, b1;
        if (!Resetn) begin
            byte_q.delete();
            exp_q.delete();
            gen_idx  = 0;
            taken    = 0;
            m_clip   = 0;
            m_busy   = 0;
            m_done   = 0;
            hold_chk = 0;
        end else begin
            cur_busy = m_busy;
            cur_done = m_done;
            nxt_done = 0;
            chk("busy", 64'(Busy_O), 64'(cur_busy));
            chk("done", 64'(Done_O), 64'(cur_done));
            chk("ready_while_idle", 64'(Pix_ready_O & ~cur_busy), 64'(0));
            if (hold_chk) begin
                chk("stall_hold_en", 64'(Wr_en_O), 64'(1));
                chk("stall_hold_word", 64'({Wr_address_O, Wr_data_O}), 64'({hold_a, hold_d}));
            end
            hold_chk = Wr_en_O && Wr_stall_I;
            hold_a   = Wr_address_O;
            hold_d   = Wr_data_O;
            if (Wr_en_O && !Wr_stall_I) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL wr_word: unexpected write addr=%h data=%h", Wr_address_O, Wr_data_O);
                end else begin
                    chk("wr_word", 64'({Wr_address_O, Wr_data_O}), 64'(exp_q.pop_front()));
                end
                if (log_n < NW) begin
                    log_a[log_n] = Wr_address_O;
                    log_d[log_n] = Wr_data_O;
                    log_c[log_n] = cyc;
                    log_n++;
                end
                taken++;
                if (taken == NW) begin
                    m_busy   = 0;
                    nxt_done = 1;
                end
            end
            if (Pix_valid_I && Pix_ready_O) begin
                y = int'(Y_I) - 16;
                u = int'(U_I) - 128;
                v = int'(V_I) - 128;
                r = fl16(76284 * y + 104595 * v);
                g = fl16(76284 * y - 25624 * u - 53281 * v);
                b = fl16(76284 * y + 132251 * u);
                m_clip += nclip(r) + nclip(g) + nclip(b);
                byte_q.push_back(sat8(r));
                byte_q.push_back(sat8(g));
                byte_q.push_back(sat8(b));
                while (byte_q.size() >= 2) begin
                    b0 = byte_q.pop_front();
                    b1 = byte_q.pop_front();
                    exp_q.push_back({18'(BASE + gen_idx), b0, b1});
                    gen_idx++;
                end
            end
            if (!cur_busy && !cur_done && Start_I) begin
                m_busy  = 1;
                taken   = 0;
                gen_idx = 0;
                m_clip  = 0;
                log_n   = 0;
                byte_q.delete();
                exp_q.delete();
            end
            m_done = nxt_done;
        end
    end

    task automatic send_pix(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
        int n = 0;
        bit got = 0;
        Y_I = y; U_I = u; V_I = v;
        Pix_valid_I = 1'b1;
        while (!got && n < 200) begin
            @(negedge Clock);
            if (Pix_ready_O) got = 1;
            else n++;
        end
        if (!got) begin
            compared++;
            mismatched++;
            $display("FAIL pix_accept_timeout: pixel %h/%h/%h not accepted", y, u, v);
        end
        @(posedge Clock); #1;
        Pix_valid_I = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < 8; i++) send_pix(tab_y[i], tab_u[i], tab_v[i]);
    endtask

    task automatic start_frame();
        Start_I = 1'b1;
        @(posedge Clock); #1;
        Start_I = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!Done_O && n < 400) begin
            @(posedge Clock); #1;
            n++;
        end
        if (!Done_O) begin
            compared++;
            mismatched++;
            $display("FAIL done_timeout: Done_O never rose");
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_wr_en"}, 64'(Wr_en_O), 64'(0));
        chk({tag, "_addr"}, 64'(Wr_address_O), 64'(0));
        chk({tag, "_data"}, 64'(Wr_data_O), 64'(0));
        chk({tag, "_busy"}, 64'(Busy_O), 64'(0));
        chk({tag, "_done"}, 64'(Done_O), 64'(0));
        chk({tag, "_ready"}, 64'(Pix_ready_O), 64'(0));
`ifdef CSC_CLIP_STATS_EN
        chk({tag, "_clip"}, 64'(Clip_count_O), 64'(0));
`endif
    endtask

    task automatic check_frame_end(input string tag);
        chk({tag, "_busy_at_done"}, 64'(Busy_O), 64'(0));
        chk({tag, "_word_count"}, 64'(log_n), 64'(NW));
        chk({tag, "_leftover"}, 64'(exp_q.size()), 64'(0));
        chk({tag, "_first_addr"}, 64'(log_a[0]), 64'(BASE));
        chk({tag, "_last_addr"}, 64'(log_a[NW-1]), 64'(BASE + NW - 1));
        chk({tag, "_done_delay"}, 64'(cyc), 64'(log_c[NW-1] + 1));
        chk({tag, "_w0"}, 64'(log_d[0]), 64'(16'hFEFE));
        chk({tag, "_w1"}, 64'(log_d[1]), 64'(16'hFE00));
        chk({tag, "_w2"}, 64'(log_d[2]), 64'(16'h0000));
        chk({tag, "_w3"}, 64'(log_d[3]), 64'(16'hFFFF));
        chk({tag, "_w4"}, 64'(log_d[4]), 64'(16'hFF00));
        chk({tag, "_w5"}, 64'(log_d[5]), 64'(16'h0000));
        chk({tag, "_w6"}, 64'(log_d[6]), 64'(16'h8282));
`ifdef CSC_CLIP_STATS_EN
        chk({tag, "_clip_lit"}, 64'(Clip_count_O), 64'(6));
        chk({tag, "_clip_model"}, 64'(Clip_count_O), 64'(m_clip));
`endif
        @(posedge Clock); #1;
        chk({tag, "_done_pulse"}, 64'(Done_O), 64'(0));
    endtask

    // Stall the second word of the frame for five cycles, then pulse Start_I mid-frame.
    task automatic stall_seq();
        int n = 0;
        while (!(Wr_en_O && Wr_address_O == 18'(BASE + 1)) && n < 200) begin
            @(posedge Clock); #1;
            n++;
        end
        chk("reach_second_word", 64'(Wr_address_O), 64'(BASE + 1));
        Wr_stall_I = 1'b1;
        repeat (5) begin
            @(posedge Clock); #1;
        end
        chk("stall_addr_held", 64'(Wr_address_O), 64'(BASE + 1));
        chk("stall_data_held", 64'(Wr_data_O), 64'(16'hFE00));
        chk("stall_ready_low", 64'(Pix_ready_O), 64'(0));
        Wr_stall_I = 1'b0;
        repeat (2) begin
            @(posedge Clock); #1;
        end
        chk("busy_before_restart", 64'(Busy_O), 64'(1));
        start_frame();
    endtask

    initial begin
        repeat (3) @(posedge Clock);
        #1;
        check_idle("reset");
        Resetn = 1'b1;
        @(posedge Clock); #1;

        start_frame();
        send_frame();
        wait_done();
        check_frame_end("frame_a");

        start_frame();
        fork
            send_frame();
            stall_seq();
        join
        wait_done();
        check_frame_end("frame_b");

        start_frame();
        for (int i = 0; i < 3; i++) send_pix(tab_y[i], tab_u[i], tab_v[i]);
        Resetn = 1'b0;
        @(posedge Clock); #1;
        check_idle("midreset");
        Resetn = 1'b1;
        @(posedge Clock); #1;

        start_frame();
        send_frame();
        wait_done();
        check_frame_end("frame_d");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
